vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator. Successor to the fixed-polarity 640x480 controller. Adds a frame-synchronous start/stop handshake, runtime coordinate down-scaling, and configurable sync polarity. A programmable output delay aligns sync and blanking with the read latency of downstream pixel memory. Sits between the pixel clock domain root and the frame-buffer read / colour output stage.

## Interface
- HVID, 640, active pixels per line
- HFP, 16, horizontal front porch (pixel clocks)
- HS, 96, hsync pulse width
- HBP, 48, horizontal back porch
- VVID, 480, active lines
- VFP, 10, vertical front porch (lines)
- VS, 2, vsync pulse width
- VBP, 33, vertical back porch
- CW, 10, counter/coordinate width; elaboration error if 2^CW < max(HC_MAX, VC_MAX)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIPE_DLY, 0, extra register stages (0..4) on hsync/vsync/video_on/sof/eol
- FCW, 8, frame counter width
- Ports:
- clk_25  in  1  pixel clock; the block's only clock
- n_rst  in  1  reset; synchronous and active-low
- enable  in  1  request to run; sampled only at frame boundaries
- scale  in  2  coordinate shift: 0 = 1x, 1 = /2, 2 = /4, 3 treated as 2
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- video_on  out  1  high in active region
- x_coordinate  out  CW  h_cnt >> scale_q
- y_coordinate  out  CW  v_cnt >> scale_q
- sof  out  1  one-cycle pulse at pixel (0,0) of each frame
- eol  out  1  one-cycle pulse at last active pixel of each active line
- running  out  1  high while state is RUN or STOP
- frame_count  out  FCW  completed-frame counter, wraps modulo 2^FCW

## Operation
- HC_MAX = HVID+HFP+HS+HBP. VC_MAX = VVID+VFP+VS+VBP.
- States:
  - IDLE: counters held at (0,0), outputs blank.
  - RUN: raster counting.
  - STOP: counting; the current frame completes, then the block returns to IDLE.
- IDLE -> RUN when enable=1. Counters stay at (0,0) on that edge, and scale is latched into scale_q.
- RUN -> STOP when enable=0 at any pixel. STOP -> RUN if enable returns to 1 before the frame ends.
- Last pixel of a frame is (HC_MAX-1, VC_MAX-1). At this pixel:
  - In RUN: counters wrap to (0,0), frame_count++, scale re-latched.
  - In STOP: next state IDLE, counters (0,0), frame_count++.
- h_cnt increments every cycle in RUN/STOP and wraps at HC_MAX-1. v_cnt increments on the h wrap and wraps at VC_MAX-1.
- Decode is done on the current counters:
  - video_on = h_cnt<HVID and v_cnt<VVID.
  - hsync active when HVID+HFP <= h_cnt < HVID+HFP+HS.
  - vsync active when VVID+VFP <= v_cnt < VVID+VFP+VS.
  - sof = (0,0).
  - eol = h_cnt==HVID-1 and v_cnt<VVID.
- All decoded outputs are gated by the state: in IDLE, video_on/sof/eol are 0 and syncs are inactive.
- scale changes mid-frame have no effect until the next latch point.

## Timing
- All outputs registered. Decode is computed from next-state counters, so the outputs after edge k describe counter values after edge k.
- x/y_coordinate have zero extra delay. hsync/vsync/video_on/sof/eol lag the coordinates by exactly PIPE_DLY cycles.
- Reset values:
  - Counters 0, state IDLE, scale_q 0, frame_count 0, running 0.
  - video_on/sof/eol 0; hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - Coordinates 0.
  - Delay-line stages reset to the same inactive values.
- Reset mid-frame: on the next edge, all outputs take their reset values. enable is ignored on the reset edge.
- Latency, IDLE to first sof: sof appears 1+PIPE_DLY cycles after the edge that samples enable=1 (for PIPE_DLY=0, in the cycle immediately after that edge).
- running rises together with the IDLE->RUN transition. It falls on the edge that enters IDLE.

## Structure
- Package vga_timing_pkg holds:
  - default 640x480 timing constants;
  - state enum (IDLE, RUN, STOP);
  - scale_t enum;
  - a function clamping scale 3 to 2.
- Sub-module vga_delay_line: parametrised depth (0 = wire) and width. It is a shift register for {hsync, vsync, video_on, sof, eol} and takes per-bit reset values.

## Test plan
- Use bench timing HVID=8, HFP=2, HS=3, HBP=2, VVID=4, VFP=1, VS=2, VBP=1. This gives HC_MAX=15, VC_MAX=8, and 120 cycles per frame.
1. Reset, then enable=1. Required: sof after 1 cycle, then again every 120 cycles. hsync low for h=10..12 only. vsync low for v=5..6. video_on for 32 pixels per frame.
2. Drop enable at pixel (3,2). Required: the frame completes and frame_count goes 0→1. running falls after (14,7). Outputs then stay blank with coordinates (0,0).
3. In STOP, re-assert enable before (14,7). Required: no gap, and the next sof arrives exactly 120 cycles after the previous one.
4. Set scale=1 mid-frame. Required: coordinates are unchanged until the wrap. Next frame, x_coordinate steps 0,0,1,1,…,3,3 over the active pixels.
5. With PIPE_DLY=2, HSYNC_POL=1: hsync high exactly 2 cycles after x_coordinate=10, for 3 cycles. eol is high 2 cycles after x=7.
6. Assert n_rst=0 at (9,3). Required: next edge gives all reset values. Release with enable=1 gives a fresh sof after 1 cycle, and frame_count reads 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared defaults, state/scale types and helpers for the VGA raster timing generator.
package vga_timing_pkg;

   localparam int unsigned DEF_HVID = 640;
   localparam int unsigned DEF_HFP  = 16;
   localparam int unsigned DEF_HS   = 96;
   localparam int unsigned DEF_HBP  = 48;
   localparam int unsigned DEF_VVID = 480;
   localparam int unsigned DEF_VFP  = 10;
   localparam int unsigned DEF_VS   = 2;
   localparam int unsigned DEF_VBP  = 33;

   typedef enum logic [1:0] {StIdle, StRun, StStop} state_t;

   typedef enum logic [1:0] {Scale1x, Scale2x, Scale4x} scale_t;

   // Encoding 3 has no meaning of its own and behaves as /4.
   function automatic scale_t clamp_scale(input logic [1:0] s);
      return (s == 2'd3) ? Scale4x : scale_t'(s);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with per-bit synchronous reset values; depth 0 is a plain wire.
module vga_delay_line #(
   parameter int unsigned      Width  = 5,
   parameter int unsigned      Depth  = 0,
   parameter logic [Width-1:0] RstVal = '0
) (
   input  logic             clk_25,
   input  logic             n_rst,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout
);

   if (Depth == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk_25 ^ n_rst;
      assign dout = din;
   end else begin : g_pipe
      logic [Width-1:0] stage_q [Depth];

      always_ff @(posedge clk_25) begin
         if (!n_rst) begin
            for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= RstVal;
         end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign dout = stage_q[Depth-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-synchronous start/stop, coordinate
// down-scaling, selectable sync polarity and a programmable delay on the decoded strobes.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned HVID      = DEF_HVID,
   parameter int unsigned HFP       = DEF_HFP,
   parameter int unsigned HS        = DEF_HS,
   parameter int unsigned HBP       = DEF_HBP,
   parameter int unsigned VVID      = DEF_VVID,
   parameter int unsigned VFP       = DEF_VFP,
   parameter int unsigned VS        = DEF_VS,
   parameter int unsigned VBP       = DEF_VBP,
   parameter int unsigned CW        = 10,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0,
   parameter int unsigned PIPE_DLY  = 0,
   parameter int unsigned FCW       = 8
) (
   input  logic           clk_25,
   input  logic           n_rst,
   input  logic           enable,
   input  logic [1:0]     scale,
   output logic           hsync,
   output logic           vsync,
   output logic           video_on,
   output logic [CW-1:0]  x_coordinate,
   output logic [CW-1:0]  y_coordinate,
   output logic           sof,
   output logic           eol,
   output logic           running,
   output logic [FCW-1:0] frame_count
);

   localparam int unsigned HC_MAX = HVID + HFP + HS + HBP;
   localparam int unsigned VC_MAX = VVID + VFP + VS + VBP;
   localparam longint unsigned CNT_RANGE = 64'd1 << CW;

   if (CNT_RANGE < longint'(HC_MAX) || CNT_RANGE < longint'(VC_MAX)) begin : g_cw_check
      $error("CW too narrow for the raster counters");
   end
   if (PIPE_DLY > 4) begin : g_dly_check
      $error("PIPE_DLY must be in 0..4");
   end

   localparam logic [CW-1:0] H_LAST = CW'(HC_MAX - 1);
   localparam logic [CW-1:0] V_LAST = CW'(VC_MAX - 1);

   // One extra bit so boundaries equal to 2^CW still compare correctly.
   localparam logic [CW:0] H_VID   = (CW+1)'(HVID);
   localparam logic [CW:0] H_SSTRT = (CW+1)'(HVID + HFP);
   localparam logic [CW:0] H_SEND  = (CW+1)'(HVID + HFP + HS);
   localparam logic [CW:0] H_EOL   = (CW+1)'(HVID - 1);
   localparam logic [CW:0] V_VID   = (CW+1)'(VVID);
   localparam logic [CW:0] V_SSTRT = (CW+1)'(VVID + VFP);
   localparam logic [CW:0] V_SEND  = (CW+1)'(VVID + VFP + VS);

   // Strobe order: {hsync, vsync, video_on, sof, eol}.
   localparam logic [4:0] DEC_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b000};

   state_t         state_q, state_d;
   scale_t         scale_q, scale_d;
   logic [CW-1:0]  h_q, h_d, v_q, v_d;
   logic [CW-1:0]  x_q, x_d, y_q, y_d;
   logic [FCW-1:0] fc_q, fc_d;
   logic           running_q, running_d;
   logic [4:0]     dec_q, dec_d, dec_dly;
   logic           frame_end;
   logic [CW:0]    h_ext, v_ext;
   logic           hs_act, vs_act, vid_act, sof_act, eol_act;

   assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

   always_comb begin
      state_d = state_q;
      scale_d = scale_q;
      h_d     = h_q;
      v_d     = v_q;
      fc_d    = fc_q;
      case (state_q)
         StIdle: begin
            h_d = '0;
            v_d = '0;
            if (enable) begin
               state_d = StRun;
               scale_d = clamp_scale(scale);
            end
         end
         StRun, StStop: begin
            if (frame_end) begin
               h_d  = '0;
               v_d  = '0;
               fc_d = fc_q + FCW'(1);
               if (state_q == StRun) begin
                  scale_d = clamp_scale(scale);
                  state_d = enable ? StRun : StStop;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               state_d = enable ? StRun : StStop;
               if (h_q == H_LAST) begin
                  h_d = '0;
                  v_d = v_q + CW'(1);
               end else begin
                  h_d = h_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            h_d     = '0;
            v_d     = '0;
         end
      endcase
   end

   // Decode looks at the next-state counters so outputs line up with the new coordinates.
   always_comb begin
      h_ext     = {1'b0, h_d};
      v_ext     = {1'b0, v_d};
      running_d = (state_d != StIdle);
      hs_act    = running_d && (h_ext >= H_SSTRT) && (h_ext < H_SEND);
      vs_act    = running_d && (v_ext >= V_SSTRT) && (v_ext < V_SEND);
      vid_act   = running_d && (h_ext < H_VID) && (v_ext < V_VID);
      sof_act   = running_d && (h_d == '0) && (v_d == '0);
      eol_act   = running_d && (h_ext == H_EOL) && (v_ext < V_VID);
      dec_d     = {hs_act ? HSYNC_POL : ~HSYNC_POL,
                   vs_act ? VSYNC_POL : ~VSYNC_POL,
                   vid_act, sof_act, eol_act};
      x_d       = h_d >> scale_d;
      y_d       = v_d >> scale_d;
   end

   always_ff @(posedge clk_25) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         scale_q   <= Scale1x;
         h_q       <= '0;
         v_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         fc_q      <= '0;
         running_q <= 1'b0;
         dec_q     <= DEC_RST;
      end else begin
         state_q   <= state_d;
         scale_q   <= scale_d;
         h_q       <= h_d;
         v_q       <= v_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fc_q      <= fc_d;
         running_q <= running_d;
         dec_q     <= dec_d;
      end
   end

   vga_delay_line #(
      .Width  (5),
      .Depth  (PIPE_DLY),
      .RstVal (DEC_RST)
   ) u_dly (
      .clk_25 (clk_25),
      .n_rst  (n_rst),
      .din    (dec_q),
      .dout   (dec_dly)
   );

   assign {hsync, vsync, video_on, sof, eol} = dec_dly;
   assign x_coordinate = x_q;
   assign y_coordinate = y_q;
   assign running      = running_q;
   assign frame_count  = fc_q;

endmodule
